snn_input_loader: RTL

- Front-end controller and back-end reporter for snn_core.
- Receives the 784-pixel image as 98 bytes from the UART receiver and unpacks each byte into 1-bit writes to the input-unit RAM (the RAM snn_core reads through addr_input_unit/q_input).
- Once the full image is written, it pulses start to snn_core, waits for done, latches digit, and hands one result byte to the UART transmitter.

---
 rtl/snn_pkg.sv | 26 ++
 rtl/snn_input_loader_bit_unpacker.sv | 45 ++++
 rtl/snn_input_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN input loader.
// SNN_ASCII_OUT_EN selects ASCII formatting of the result byte.
package snn_pkg;

   localparam int         NUM_PIXELS_DEFAULT = 784;
   localparam int         BYTES_PER_IMAGE    = NUM_PIXELS_DEFAULT / 8;
   localparam logic [7:0] ASCII_ZERO         = 8'h30;
   localparam logic [7:0] ASCII_QMARK        = 8'h3F;

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      KICK,
      WAIT_DONE,
      SEND
   } loader_state_t;

   function automatic logic [7:0] format_result(input logic [3:0] r);
`ifdef SNN_ASCII_OUT_EN
      format_result = (r > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'h0, r});
`else
      format_result = {4'h0, r};
`endif
   endfunction

endpackage

// File: rtl/snn_input_loader_bit_unpacker.sv
// Serialises one byte LSB-first over 8 cycles; busy doubles as the RAM write strobe.
module bit_unpacker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_data,
   output logic       busy,
   output logic       bit_out,
   output logic       last_bit
);
   logic [7:0] shift_q;
   logic [7:0] shift_d;
   logic [2:0] bit_cnt_q;
   logic       busy_q;

   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_shift
         assign shift_d[gi] = shift_q[gi+1];
      end
   endgenerate
   assign shift_d[7] = 1'b0;

   // A load on the last bit restarts the sequence with no gap cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q   <= 8'h00;
         bit_cnt_q <= 3'd0;
         busy_q    <= 1'b0;
      end else if (load) begin
         shift_q   <= load_data;
         bit_cnt_q <= 3'd0;
         busy_q    <= 1'b1;
      end else if (busy_q) begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) busy_q <= 1'b0;
      end
   end

   assign busy     = busy_q;
   assign bit_out  = shift_q[0];
   assign last_bit = busy_q && (bit_cnt_q == 3'd7);

endmodule

// File: rtl/snn_input_loader.sv
// Loads a packed image into the SNN input RAM, kicks the core and returns its result.
// Define SNN_ASCII_OUT_EN to send the result as an ASCII digit.
module snn_input_loader
   import snn_pkg::*;
#(
   parameter int NUM_PIXELS = 784,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_rdy,
   input  logic [7:0]            rx_data,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_data,
   output logic                  ram_we,
   output logic                  start,
   input  logic                  done,
   input  logic [3:0]            digit,
   input  logic                  tx_busy,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   output logic                  overrun
);
   loader_state_t         state_q;
   logic [ADDR_WIDTH-1:0] pix_cnt_q;
   logic [7:0]            buf_q;
   logic                  buf_full_q;
   logic [3:0]            result_q;
   logic                  start_q;
   logic                  tx_start_q;
   logic [7:0]            tx_data_q;
   logic                  overrun_q;

   logic       up_load;
   logic [7:0] up_data;
   logic       up_busy;
   logic       up_bit;
   logic       up_last;
   logic       frame_end;

   assign frame_end = up_last && (pix_cnt_q == ADDR_WIDTH'(NUM_PIXELS - 1));

   // The holding buffer always takes priority over a fresh byte.
   always_comb begin
      up_load = 1'b0;
      up_data = rx_data;
      case (state_q)
         IDLE: begin
            if (buf_full_q) begin
               up_load = 1'b1;
               up_data = buf_q;
            end else if (rx_rdy) begin
               up_load = 1'b1;
            end
         end
         UNPACK: begin
            if (up_last && !frame_end && buf_full_q) begin
               up_load = 1'b1;
               up_data = buf_q;
            end
         end
         default: ;
      endcase
   end

   bit_unpacker u_unpacker (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (up_load),
      .load_data (up_data),
      .busy      (up_busy),
      .bit_out   (up_bit),
      .last_bit  (up_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pix_cnt_q  <= '0;
         buf_q      <= 8'h00;
         buf_full_q <= 1'b0;
         result_q   <= 4'h0;
         start_q    <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         overrun_q  <= 1'b0;
      end else begin
         start_q    <= 1'b0;
         tx_start_q <= 1'b0;
         if (up_busy) pix_cnt_q <= pix_cnt_q + ADDR_WIDTH'(1);
         case (state_q)
            IDLE: begin
               if (buf_full_q) begin
                  buf_full_q <= rx_rdy;
                  if (rx_rdy) buf_q <= rx_data;
                  state_q <= UNPACK;
               end else if (rx_rdy) begin
                  if (pix_cnt_q == '0) overrun_q <= 1'b0;
                  state_q <= UNPACK;
               end
            end
            UNPACK: begin
               if (up_load) buf_full_q <= 1'b0;
               if (rx_rdy) begin
                  if (buf_full_q) begin
                     overrun_q <= 1'b1;
                  end else begin
                     buf_q      <= rx_data;
                     buf_full_q <= 1'b1;
                  end
               end
               if (frame_end) begin
                  start_q <= 1'b1;
                  state_q <= KICK;
               end else if (up_last && !buf_full_q) begin
                  state_q <= IDLE;
               end
            end
            KICK: begin
               if (rx_rdy) overrun_q <= 1'b1;
               pix_cnt_q <= '0;
               state_q   <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (rx_rdy) overrun_q <= 1'b1;
               if (done) begin
                  result_q <= digit;
                  // Idle transmitter: skip SEND so the reply leaves one cycle after done.
                  if (!tx_busy) begin
                     tx_start_q <= 1'b1;
                     tx_data_q  <= format_result(digit);
                     state_q    <= IDLE;
                  end else begin
                     state_q <= SEND;
                  end
               end
            end
            SEND: begin
               if (rx_rdy) overrun_q <= 1'b1;
               if (!tx_busy) begin
                  tx_start_q <= 1'b1;
                  tx_data_q  <= format_result(result_q);
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ram_addr = pix_cnt_q;
   assign ram_data = up_bit;
   assign ram_we   = up_busy;
   assign start    = start_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign overrun  = overrun_q;

endmodule
